// File: rtl/sdr_ref_timer_pkg.sv
// Shared SDRAM refresh-timing defaults and the pending-count update decode.
package sdr_ref_timer_pkg;

  localparam int unsigned DefClkPer100us = 10000;
  localparam int unsigned DefRefInterval = 780;
  localparam int unsigned DefMaxPending  = 4;
  localparam int unsigned DefPendW       = 3;

  typedef enum logic [1:0] {
    PendHold,
    PendInc,
    PendDec,
    PendClr
  } pend_op_e;

  // A tick and an ack edge in the same cycle cancel out.
  function automatic pend_op_e pend_op(input logic init_done, input logic tick,
                                       input logic ack_edge);
    if (!init_done) begin
      return PendClr;
    end else if (tick && !ack_edge) begin
      return PendInc;
    end else if (ack_edge && !tick) begin
      return PendDec;
    end
    return PendHold;
  endfunction

endpackage

// File: rtl/sdr_ref_timer_tick_cnt.sv
// Up-counter that pulses tick at LIMIT-1 and latches done; wraps or saturates by WRAP.
module sdr_ref_timer_tick_cnt #(
  parameter int unsigned LIMIT = 10,
  parameter bit          WRAP  = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick,
  output logic done
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(LIMIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            at_last;

  assign at_last = (cnt_q == Last);
  // In saturating mode the tick fires only once, on the edge that sets done.
  assign tick    = en & at_last & (WRAP | ~done_q);
  assign done    = done_q;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (en) begin
      if (at_last) begin
        done_d = 1'b1;
        if (WRAP) begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/sdr_ref_timer.sv
// Power-up 100 us qualifier and auto-refresh request/backlog tracker for the SDRAM controller.
module sdr_ref_timer
  import sdr_ref_timer_pkg::*;
#(
  parameter int unsigned CLK_PER_100US = DefClkPer100us,
  parameter int unsigned REF_INTERVAL  = DefRefInterval,
  parameter int unsigned MAX_PENDING   = DefMaxPending,
  parameter int unsigned PEND_W        = DefPendW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init_done,
  input  logic              ref_en,
  input  logic              ref_ack,
  output logic              delay_100us,
  output logic              ref_req,
  output logic              ref_urgent,
  output logic [PEND_W-1:0] ref_pending,
  output logic              ref_overflow
);

  localparam logic [PEND_W-1:0] MaxPend = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] UrgThr  = PEND_W'(MAX_PENDING - 1);

  logic              unused_pwr_tick;
  logic              unused_ivl_done;
  logic              ivl_tick;
  logic              ack_d_q;
  logic              ack_edge;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              req_q, urg_q;
  logic [PEND_W-1:0] pend_out_q;

  sdr_ref_timer_tick_cnt #(
    .LIMIT (CLK_PER_100US),
    .WRAP  (1'b0)
  ) u_pwr_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (1'b1),
    .clr     (1'b0),
    .tick    (unused_pwr_tick),
    .done    (delay_100us)
  );

  sdr_ref_timer_tick_cnt #(
    .LIMIT (REF_INTERVAL),
    .WRAP  (1'b1)
  ) u_ivl_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (init_done & ref_en),
    .clr     (~init_done),
    .tick    (ivl_tick),
    .done    (unused_ivl_done)
  );

  // Only the rising edge of a possibly multi-cycle ack retires a refresh.
  assign ack_edge = ref_ack & ~ack_d_q;

  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    unique case (pend_op(init_done, ivl_tick, ack_edge))
      PendClr: pend_d = '0;
      PendInc: begin
        if (pend_q == MaxPend) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end
      PendDec: begin
        if (pend_q != '0) begin
          pend_d = pend_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_d_q    <= 1'b0;
      pend_q     <= '0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
      urg_q      <= 1'b0;
      pend_out_q <= '0;
    end else begin
      ack_d_q    <= ref_ack;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
      req_q      <= (pend_q != '0);
      urg_q      <= (pend_q >= UrgThr);
      pend_out_q <= pend_q;
    end
  end

  assign ref_req      = req_q;
  assign ref_urgent   = urg_q;
  assign ref_pending  = pend_out_q;
  assign ref_overflow = ovf_q;

endmodule

// File: tb/tb_sdr_ref_timer.sv
// Randomized bench for sdr_ref_timer against a cycle-count reference model.
module tb_sdr_ref_timer;

  localparam int unsigned ClkPer  = 20;
  localparam int unsigned RefIvl  = 10;
  localparam int unsigned MaxPend = 4;
  localparam int unsigned PendW   = 3;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             init_done = 1'b0;
  logic             ref_en = 1'b0;
  logic             ref_ack = 1'b0;
  logic             delay_100us;
  logic             ref_req;
  logic             ref_urgent;
  logic [PendW-1:0] ref_pending;
  logic             ref_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts of edges / enabled cycles, and the owed-refresh backlog.
  int m_pow, m_en_cnt, m_pend, e_pend;
  bit m_ack_prev, m_ovf, e_req, e_urg;

  sdr_ref_timer #(
    .CLK_PER_100US (ClkPer),
    .REF_INTERVAL  (RefIvl),
    .MAX_PENDING   (MaxPend),
    .PEND_W        (PendW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .init_done    (init_done),
    .ref_en       (ref_en),
    .ref_ack      (ref_ack),
    .delay_100us  (delay_100us),
    .ref_req      (ref_req),
    .ref_urgent   (ref_urgent),
    .ref_pending  (ref_pending),
    .ref_overflow (ref_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pow = 0; m_en_cnt = 0; m_pend = 0; e_pend = 0;
    m_ack_prev = 0; m_ovf = 0; e_req = 0; e_urg = 0;
  endtask

  // Advance the model across one rising edge using the inputs now being driven.
  task automatic model_edge();
    bit en, tick, aedge;
    en    = init_done && ref_en;
    tick  = en && (((m_en_cnt + 1) % RefIvl) == 0);
    aedge = ref_ack && !m_ack_prev;
    e_req  = (m_pend != 0);
    e_urg  = (m_pend >= int'(MaxPend) - 1);
    e_pend = m_pend;
    if (!init_done) begin
      m_pend   = 0;
      m_en_cnt = 0;
    end else begin
      if (en) m_en_cnt++;
      if (tick && !aedge) begin
        if (m_pend == MaxPend) m_ovf = 1;
        else m_pend++;
      end else if (aedge && !tick) begin
        if (m_pend > 0) m_pend--;
      end
    end
    m_ack_prev = ref_ack;
    m_pow++;
  endtask

  task automatic check_outputs(input string ph);
    check_eq({ph, ".delay_100us"}, int'(delay_100us), int'(m_pow >= ClkPer));
    check_eq({ph, ".ref_req"}, int'(ref_req), int'(e_req));
    check_eq({ph, ".ref_urgent"}, int'(ref_urgent), int'(e_urg));
    check_eq({ph, ".ref_pending"}, int'(ref_pending), e_pend);
    check_eq({ph, ".ref_overflow"}, int'(ref_overflow), int'(m_ovf));
  endtask

  // Called at a falling edge; drives inputs, crosses one rising edge, checks at the next fall.
  task automatic run_cycle(input string ph, input bit id, input bit re, input bit ack);
    init_done = id;
    ref_en    = re;
    ref_ack   = ack;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs(ph);
  endtask

  // Async reset mid-cycle: outputs must clear before any clock edge.
  task automatic do_reset(input string ph);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs({ph, ".async"});
    @(negedge clk);
    check_outputs({ph, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("por");

    // Power-up count with init held off; random acks must not create requests.
    for (int i = 0; i < 25; i++) begin
      run_cycle("pwrup", 1'b0, 1'($urandom), 1'($urandom));
    end

    // Refresh ticks with no acks: backlog fills, then overflow.
    for (int i = 0; i < 60; i++) begin
      run_cycle("fill", 1'b1, 1'b1, 1'b0);
    end
    check_eq("fill.overflow_seen", int'(ref_overflow), 1);

    // Drain with multi-cycle acks.
    for (int i = 0; i < 12; i++) begin
      run_cycle("drain", 1'b1, 1'b0, (i % 3) != 2);
    end
    check_eq("drain.empty", int'(ref_pending), 0);

    // Interval hold while disabled, then resume.
    for (int i = 0; i < 6; i++) run_cycle("hold", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) run_cycle("hold", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) run_cycle("hold", 1'b1, 1'b1, 1'b0);

    do_reset("midop");

    // Random traffic with occasional init drops and resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rnd");
      end else begin
        run_cycle("rnd", $urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 5) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdr_ref_timer.md
Name: sdr_ref_timer

Overview:
Timing source upstream of the SDRAM command controller.
- Generates the power-up 100 us qualifier (delay_100us) that starts the init sequence.
- Generates periodic auto-refresh requests (ref_req) and tracks a backlog of owed refreshes.
- Consumes the controller's ref_ack; flags refresh starvation.

Parameters:
CLK_PER_100US, 10000, clk cycles in 100 us (100 MHz default)
REF_INTERVAL, 780, clk cycles between refresh ticks (7.8 us at 100 MHz)
MAX_PENDING, 4, maximum owed refreshes held in backlog (1..7)
PEND_W, 3, width of pending count; must hold MAX_PENDING

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
init_done  in  1  controller init complete; enables refresh timing
ref_en  in  1  refresh timer enable; low = interval counter holds
ref_ack  in  1  refresh accepted by controller; may be high for multiple cycles
delay_100us  out  1  high once 100 us elapsed after reset release; stays high until reset
ref_req  out  1  registered; high while pending != 0
ref_urgent  out  1  registered; high while pending >= MAX_PENDING-1
ref_pending  out  PEND_W  owed refresh count
ref_overflow  out  1  sticky; a tick arrived with backlog full

Behaviour:
- Reset (reset_n=0, async): all outputs 0; power counter, interval counter, pending count and ack-edge register cleared.
- Power-up counter:
  - Increments every cycle after reset release and saturates at CLK_PER_100US-1.
  - delay_100us is registered high on the CLK_PER_100US-th rising edge after reset_n deasserts.
  - Independent of init_done and ref_en.
- Interval counter:
  - Counts only when init_done=1 and ref_en=1.
  - Holds its value when ref_en=0.
  - Cleared to 0 when init_done=0.
  - At REF_INTERVAL-1 it wraps to 0 and issues a one-cycle internal tick.
  - First tick lands REF_INTERVAL enabled cycles after init_done rises.
- Ack detection: ack_edge = ref_ack & ~ref_ack_d, where ref_ack_d is ref_ack registered. Only the rising edge consumes a refresh; multi-cycle ack counts once.
- Pending update, per cycle:
  - tick & !ack_edge: pending+1. If pending==MAX_PENDING, pending holds and ref_overflow sets.
  - ack_edge & !tick: pending-1. If pending==0, ignored (no underflow).
  - tick & ack_edge: pending unchanged.
  - init_done=0: pending forced to 0. ref_overflow is not cleared.
- Outputs:
  - ref_req, ref_urgent and ref_pending update on the edge after the pending change (1-cycle latency).
  - ref_req falls on the cycle after the last ack edge.
- ref_overflow is cleared only by reset.
- Reset mid-operation: everything clears immediately. The power-up delay restarts and delay_100us drops until re-counted.

Decomposition:
- Shared parameter file sdr_para gets CLK_PER_100US, REF_INTERVAL, MAX_PENDING and PEND_W defaults, next to the existing tRP/tRFC cycle counts.
- One sub-module, sdr_tick_cnt, instanced twice (power-up counter and interval counter):
  - Parameter LIMIT; inputs en and clr.
  - Outputs tick (one cycle at LIMIT-1) and done (sticky).
  - Wrap mode selectable by parameter.

Test Plan (CLK_PER_100US=20, REF_INTERVAL=10, MAX_PENDING=4):
1. Release reset_n, hold init_done=0 -> delay_100us low for 19 edges, high on edge 20, stays high; ref_req stays 0 throughout.
2. init_done=1, ref_en=1, ref_ack=0 -> ref_req rises 11 edges after init_done (tick at 10, +1 latency). Pending reaches 4 by edge 41; ref_urgent high from pending=3. Tick at 50 sets ref_overflow while pending stays 4.
3. Pending=2, ref_ack high for 3 cycles -> pending=1 one edge after ack rise, ref_req stays high. Second 1-cycle ack -> pending=0, ref_req low next edge.
4. Ack rising edge on the same cycle as a tick, pending=2 -> pending stays 2, no overflow. Ack with pending=0 -> pending stays 0.
5. ref_en=0 for 25 cycles at interval count 6 -> no ticks. After re-enable, the next tick arrives 4 cycles later.
6. Pending=3, overflow=1, assert reset_n=0 mid-interval -> all outputs 0 without waiting for a clock edge. After release, delay_100us returns only after 20 edges.
